// File: rtl/mdu_hilo_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// The master drives the request fields; the slave returns status and HI/LO.
interface mdu_hilo_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_hilo_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results land on HI/LO after a fixed latency; cancel or reset drops an in-flight op.
module mdu_hilo_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic               i_clk,
    input  logic               i_reset,
    mdu_hilo_unit_if.slave     bus
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic {StIdle, StRun} state_e;

    state_e           r_state, w_state;
    logic [CntW-1:0]  r_cnt, w_cnt;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic [WIDTH-1:0] r_hi, w_hi;
    logic [WIDTH-1:0] r_lo, w_lo;
    logic [WIDTH-1:0] r_a, w_a;
    logic [WIDTH-1:0] r_b, w_b;
    // Only the low two op bits are kept: bit 1 selects divide, bit 0 unsigned.
    logic [1:0]       r_op, w_op;

    logic [2*WIDTH-1:0] w_prod;
    logic               w_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_div_b, w_uq, w_ur, w_q, w_r;

    always_comb begin
        w_signed = ~r_op[0];
        w_a_neg  = w_signed & r_a[WIDTH-1];
        w_b_neg  = w_signed & r_b[WIDTH-1];
        // Sign-extending before an unsigned multiply gives the signed product bits.
        w_prod   = {{WIDTH{w_a_neg}}, r_a} * {{WIDTH{w_b_neg}}, r_b};
        w_abs_a  = w_a_neg ? (~r_a + 1'b1) : r_a;
        w_abs_b  = w_b_neg ? (~r_b + 1'b1) : r_b;
        w_div_b  = (r_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_abs_b;
        w_uq     = w_abs_a / w_div_b;
        w_ur     = w_abs_a % w_div_b;
        // min / -1 wraps back to min through the negate, with zero remainder.
        w_q      = (w_a_neg ^ w_b_neg) ? (~w_uq + 1'b1) : w_uq;
        w_r      = w_a_neg ? (~w_ur + 1'b1) : w_ur;
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_hi    = r_hi;
        w_lo    = r_lo;
        w_a     = r_a;
        w_b     = r_b;
        w_op    = r_op;
        unique case (r_state)
            StIdle: begin
                if (bus.start && !bus.cancel) begin
                    case (bus.op)
                        OpMult, OpMultu, OpDiv, OpDivu: begin
                            w_a     = bus.a;
                            w_b     = bus.b;
                            w_op    = bus.op[1:0];
                            w_busy  = 1'b1;
                            w_cnt   = bus.op[1] ? DivLoad : MultLoad;
                            w_state = StRun;
                        end
                        OpMthi:  w_hi = bus.a;
                        OpMtlo:  w_lo = bus.a;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (bus.cancel) begin
                    w_state = StIdle;
                    w_busy  = 1'b0;
                    w_cnt   = '0;
                end else if (r_cnt == '0) begin
                    w_state = StIdle;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    if (!r_op[1]) begin
                        w_hi = w_prod[2*WIDTH-1:WIDTH];
                        w_lo = w_prod[WIDTH-1:0];
                    end else if (r_b != '0) begin
                        w_hi = w_r;
                        w_lo = w_q;
                    end
                end else begin
                    w_cnt = r_cnt - CntW'(1);
                end
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_hi    <= w_hi;
            r_lo    <= w_lo;
            r_a     <= w_a;
            r_b     <= w_b;
            r_op    <= w_op;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: doc/mdu_hilo_unit.md
Name: mdu_hilo_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, placed beside the execute-stage ALU.
- Performs signed/unsigned multiply and divide with configurable latencies, plus direct HI/LO writes (mthi/mtlo).
- Exposes busy so the hazard unit can stall mfhi/mflo and further MDU ops.
- Supports cancellation so an exception or interrupt in the issuing instruction discards an in-flight op.

Parameters:
- WIDTH, 32: operand width and width of each of HI and LO.
- MULT_CYCLES, 5: cycles busy stays high for mult/multu (>=1).
- DIV_CYCLES, 10: cycles busy stays high for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue request, qualified by op.
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-op.
- a  input  WIDTH  rs operand (multiplicand/dividend; mthi/mtlo data).
- b  input  WIDTH  rt operand (multiplier/divisor).
- cancel  input  1  exception flush; kills the current issue or the in-flight op.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse on the edge HI/LO are updated by mult/div.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, done=0, counter=0, operand/op latches cleared; state IDLE.
- States are IDLE and RUN, with a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
- Issue rules:
  - Accepted only when start=1, busy=0 and cancel=0.
  - start while busy=1 is ignored: no queueing, no effect on the running op.
  - op 6 and 7 are ignored.
- mthi/mtlo: single-cycle, no busy. hi<=a or lo<=a at the accepting edge. done stays 0.
- mult/multu/div/divu accept:
  - At the accepting edge k: latch a, b, op; busy<=1; counter<=N-1, where N = MULT_CYCLES or DIV_CYCLES; go to RUN.
  - In RUN, counter decrements each edge.
  - At the edge where counter==0: hi/lo<=result, done<=1 for one cycle, busy<=0, return to IDLE.
  - busy is therefore high for exactly N cycles; hi/lo are visible the cycle busy drops.
  - A new start may be accepted in the first cycle busy=0.
- hi/lo hold their old values throughout RUN. The result is computed from the latched operands; a/b changing after issue has no effect.
- Arithmetic:
  - mult: signed 2*WIDTH product; hi=upper WIDTH bits, lo=lower.
  - multu: unsigned 2*WIDTH product; hi=upper WIDTH bits, lo=lower.
  - div/divu: lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed min / -1 (0x80000000 / 0xFFFFFFFF at WIDTH=32): lo=min (0x80000000), hi=0.
  - Divide by zero (div or divu): op runs its full DIV_CYCLES, done pulses, hi and lo are left unchanged.
- Cancel:
  - cancel=1 with start=1 in the same cycle: issue suppressed, including mthi/mtlo.
  - cancel=1 during RUN: next edge busy<=0, counter<=0, IDLE, no done, hi/lo unchanged.
  - cancel=1 on the final RUN cycle (counter==0): cancel wins, no write.
- reset asserted mid-RUN: immediate return to reset values; the pending result is lost.
- Purely synchronous outputs apart from reset; no combinational path from inputs to outputs.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=0x00000003 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse 1 cycle.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then divu same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- Signed edge cases:
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Preload hi=0x11, lo=0x22 via mthi/mtlo, then divu by 0 -> done pulses, hi=0x11, lo=0x22.
- Issue-while-busy:
  - Issue mult, then start mtlo a=0x55 on cycle 2 of RUN -> mtlo ignored, final lo = product.
  - start accepted the cycle busy falls -> second op runs its full N cycles.
- Cancel/reset mid-op:
  - mult issued, cancel on cycle 3 -> busy low next cycle, no done, hi/lo keep pre-issue values.
  - reset pulse mid-div -> hi=lo=0, busy=0 asynchronously.
